// File: rtl/l2_request_arbiter.sv
// Purpose: shares the single L2 request port between the L1 dcache and L1 icache, holding each grant until L2 fulfils it.
// Latency: one arbitration cycle from request to l2_req_valid; fulfilled pulses follow l2_req_fulfilled combinationally.
// Backpressure: the losing requester waits with valid held; one idle cycle follows every completion before re-arbitration.
module l2_request_arbiter #(
   parameter int ADDR_WIDTH            = 32,
   parameter int XLEN                  = 32,
   parameter int FIXED_DCACHE_PRIORITY = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   // dcache side (request type: 0 = LOAD, 1 = STORE)
   input  logic                  d_req_valid,
   input  logic                  d_req_type,
   input  logic [ADDR_WIDTH-1:0] d_req_address,
   input  logic [XLEN-1:0]       d_req_store_word,
   output logic                  d_req_fulfilled,
   // icache side, always a load
   input  logic                  i_req_valid,
   input  logic [ADDR_WIDTH-1:0] i_req_address,
   output logic                  i_req_fulfilled,
   // load data shared by both requesters
   output logic [XLEN-1:0]       req_loaded_word,
   // L2 controller side
   output logic                  l2_req_valid,
   output logic                  l2_req_type,
   output logic [ADDR_WIDTH-1:0] l2_req_address,
   output logic [XLEN-1:0]       l2_req_store_word,
   input  logic                  l2_req_fulfilled,
   input  logic [XLEN-1:0]       l2_req_loaded_word,
   // debug: 00 none, 01 dcache, 10 icache
   output logic [1:0]            grant_owner
);

   localparam logic OP_LOAD = 1'b0;

   // State codes double as the grant_owner debug encoding.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_GRANT_D = 2'b01,
      ST_GRANT_I = 2'b10
   } state_e;

   state_e state_q;
   // 0 = dcache was served last, 1 = icache was served last; a tie goes to the other one.
   logic   last_grant_q;

   // Grant FSM: arbitrate in IDLE, hold the grant until L2 fulfils, then always pass through IDLE once.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (d_req_valid && i_req_valid) begin
                  if ((FIXED_DCACHE_PRIORITY != 0) || last_grant_q) begin
                     state_q <= ST_GRANT_D;
                  end else begin
                     state_q <= ST_GRANT_I;
                  end
               end else if (d_req_valid) begin
                  state_q <= ST_GRANT_D;
               end else if (i_req_valid) begin
                  state_q <= ST_GRANT_I;
               end
            end
            ST_GRANT_D: begin
               if (l2_req_fulfilled) begin
                  last_grant_q <= 1'b0;
                  state_q      <= ST_IDLE;
               end
            end
            ST_GRANT_I: begin
               if (l2_req_fulfilled) begin
                  last_grant_q <= 1'b1;
                  state_q      <= ST_IDLE;
               end
            end
            default: begin
               state_q      <= state_e'('x);
               last_grant_q <= 1'bx;
            end
         endcase
      end
   end

   // Moore port decode from the registered state; fulfilled is gated so only the owner ever sees it.
   always_comb begin
      l2_req_valid      = 1'b0;
      l2_req_type       = OP_LOAD;
      l2_req_address    = '0;
      l2_req_store_word = '0;
      d_req_fulfilled   = 1'b0;
      i_req_fulfilled   = 1'b0;
      grant_owner       = 2'b00;
      case (state_q)
         ST_IDLE: begin
         end
         ST_GRANT_D: begin
            l2_req_valid      = 1'b1;
            l2_req_type       = d_req_type;
            l2_req_address    = d_req_address;
            l2_req_store_word = d_req_store_word;
            d_req_fulfilled   = l2_req_fulfilled;
            grant_owner       = 2'b01;
         end
         ST_GRANT_I: begin
            l2_req_valid      = 1'b1;
            l2_req_address    = i_req_address;
            i_req_fulfilled   = l2_req_fulfilled;
            grant_owner       = 2'b10;
         end
         default: begin
            l2_req_valid      = 1'bx;
            l2_req_type       = 1'bx;
            l2_req_address    = 'x;
            l2_req_store_word = 'x;
            d_req_fulfilled   = 1'bx;
            i_req_fulfilled   = 1'bx;
            grant_owner       = 2'bxx;
         end
      endcase
   end

   // Load data is only meaningful in the cycle a fulfilled pulse is high.
   assign req_loaded_word = l2_req_loaded_word;

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Purpose: self-checking bench for l2_request_arbiter, round-robin and fixed-priority instances driven in parallel.
// Latency: expectations come from a transaction-level model of who owns the L2 port in each cycle.
// Backpressure: requesters hold valid until their fulfilled pulse; the L2 responder fulfils after a programmable delay.
module tb_l2_request_arbiter;

   localparam int   AW    = 32;
   localparam int   XW    = 32;
   localparam logic LOAD  = 1'b0;
   localparam logic STORE = 1'b1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset;
   logic          d_req_valid, d_req_type, i_req_valid, l2_req_fulfilled;
   logic [AW-1:0] d_req_address, i_req_address;
   logic [XW-1:0] d_req_store_word, l2_req_loaded_word;

   logic          rr_dful, rr_iful, rr_valid, rr_type;
   logic [AW-1:0] rr_addr;
   logic [XW-1:0] rr_store, rr_word;
   logic [1:0]    rr_owner;
   logic          fx_dful, fx_iful, fx_valid, fx_type;
   logic [AW-1:0] fx_addr;
   logic [XW-1:0] fx_store, fx_word;
   logic [1:0]    fx_owner;

   l2_request_arbiter #(.ADDR_WIDTH(AW), .XLEN(XW), .FIXED_DCACHE_PRIORITY(0)) u_rr (
      .clk(clk), .reset(reset),
      .d_req_valid(d_req_valid), .d_req_type(d_req_type), .d_req_address(d_req_address),
      .d_req_store_word(d_req_store_word), .d_req_fulfilled(rr_dful),
      .i_req_valid(i_req_valid), .i_req_address(i_req_address), .i_req_fulfilled(rr_iful),
      .req_loaded_word(rr_word),
      .l2_req_valid(rr_valid), .l2_req_type(rr_type), .l2_req_address(rr_addr),
      .l2_req_store_word(rr_store), .l2_req_fulfilled(l2_req_fulfilled),
      .l2_req_loaded_word(l2_req_loaded_word), .grant_owner(rr_owner)
   );

   l2_request_arbiter #(.ADDR_WIDTH(AW), .XLEN(XW), .FIXED_DCACHE_PRIORITY(1)) u_fx (
      .clk(clk), .reset(reset),
      .d_req_valid(d_req_valid), .d_req_type(d_req_type), .d_req_address(d_req_address),
      .d_req_store_word(d_req_store_word), .d_req_fulfilled(fx_dful),
      .i_req_valid(i_req_valid), .i_req_address(i_req_address), .i_req_fulfilled(fx_iful),
      .req_loaded_word(fx_word),
      .l2_req_valid(fx_valid), .l2_req_type(fx_type), .l2_req_address(fx_addr),
      .l2_req_store_word(fx_store), .l2_req_fulfilled(l2_req_fulfilled),
      .l2_req_loaded_word(l2_req_loaded_word), .grant_owner(fx_owner)
   );

   int vectors     = 0;
   int miscompares = 0;

   // bench control
   bit use_fx = 0, rnd = 0, l2_force = 0, d_reissue = 0, i_reissue = 0, chk_en = 0;
   int lat = 2, gcnt = 0;

   // reference model: who owns the port (0 none, 1 dcache, 2 icache) and who was served last
   int m_owner = 0;
   int m_last  = 2;
   bit e_dful, e_iful;

   // snapshot of the instance under test, taken at the falling edge
   logic          s_valid, s_type, s_dful, s_iful;
   logic [AW-1:0] s_addr;
   logic [XW-1:0] s_store, s_word;
   logic [1:0]    s_owner;

   // grant order as observed on the DUT's grant_owner output
   int   dut_grants[$];
   int   dut_i_over_d = 0;
   logic [1:0] prev_owner = 2'b00;
   logic prev_dv = 1'b0, prev_iv = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic int gr(input int k);
      return (k < dut_grants.size()) ? dut_grants[k] : -1;
   endfunction

   task automatic new_d();
      d_req_valid      = 1'b1;
      d_req_type       = 1'($urandom_range(0, 1));
      d_req_address    = $urandom;
      d_req_store_word = $urandom;
   endtask

   task automatic new_i();
      i_req_valid   = 1'b1;
      i_req_address = $urandom;
   endtask

   // Requesters drop (or reissue) after their own fulfilled pulse; L2 fulfils after lat granted cycles.
   task automatic drive_next();
      if (e_dful) begin
         if (rnd ? ($urandom_range(0, 1) == 1) : d_reissue) begin
            if (rnd) new_d();
         end else begin
            d_req_valid = 1'b0;
         end
      end else if (rnd && !d_req_valid && $urandom_range(0, 2) == 0) begin
         new_d();
      end
      if (e_iful) begin
         if (rnd ? ($urandom_range(0, 1) == 1) : i_reissue) begin
            if (rnd) new_i();
         end else begin
            i_req_valid = 1'b0;
         end
      end else if (rnd && !i_req_valid && $urandom_range(0, 2) == 0) begin
         new_i();
      end
      if (rnd) begin
         l2_req_fulfilled   = ($urandom_range(0, 3) == 0);
         l2_req_loaded_word = $urandom;
      end else if (l2_force) begin
         l2_req_fulfilled = 1'b1;
      end else if (m_owner != 0) begin
         gcnt++;
         l2_req_fulfilled = (gcnt >= lat);
      end else begin
         gcnt             = 0;
         l2_req_fulfilled = 1'b0;
      end
   endtask

   // One clock: sample and compare at negedge, advance the model, then drive the next inputs after posedge.
   task automatic tick();
      logic          e_valid, e_type;
      logic [AW-1:0] e_addr;
      logic [XW-1:0] e_store;
      logic [1:0]    e_owner;
      @(negedge clk);
      if (use_fx) begin
         s_valid = fx_valid; s_type = fx_type; s_addr = fx_addr; s_store = fx_store;
         s_dful = fx_dful; s_iful = fx_iful; s_word = fx_word; s_owner = fx_owner;
      end else begin
         s_valid = rr_valid; s_type = rr_type; s_addr = rr_addr; s_store = rr_store;
         s_dful = rr_dful; s_iful = rr_iful; s_word = rr_word; s_owner = rr_owner;
      end
      if (s_owner != 2'b00 && prev_owner == 2'b00) begin
         dut_grants.push_back(int'(s_owner));
         if (s_owner == 2'b10 && prev_dv && prev_iv) dut_i_over_d++;
      end
      prev_owner = s_owner;
      prev_dv    = d_req_valid;
      prev_iv    = i_req_valid;

      e_owner = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
      e_valid = (m_owner != 0);
      e_type  = (m_owner == 1) ? d_req_type : LOAD;
      e_addr  = (m_owner == 1) ? d_req_address : (m_owner == 2) ? i_req_address : '0;
      e_store = (m_owner == 1) ? d_req_store_word : '0;
      e_dful  = (m_owner == 1) && l2_req_fulfilled;
      e_iful  = (m_owner == 2) && l2_req_fulfilled;
      if (chk_en) begin
         chk("m_valid", s_valid, e_valid);
         chk("m_type", s_type, e_type);
         chk("m_addr", s_addr, e_addr);
         chk("m_store", s_store, e_store);
         chk("m_dful", s_dful, e_dful);
         chk("m_iful", s_iful, e_iful);
         chk("m_owner", s_owner, e_owner);
         chk("m_word", s_word, l2_req_loaded_word);
         if (m_owner == 1) chk("proto_d_valid_held", d_req_valid, 1'b1);
         if (m_owner == 2) chk("proto_i_valid_held", i_req_valid, 1'b1);
      end

      if (reset) begin
         m_owner = 0;
         m_last  = 2;
      end else if (m_owner == 0) begin
         if (d_req_valid && i_req_valid) m_owner = (use_fx || m_last == 2) ? 1 : 2;
         else if (d_req_valid)           m_owner = 1;
         else if (i_req_valid)           m_owner = 2;
      end else if (l2_req_fulfilled) begin
         m_last  = m_owner;
         m_owner = 0;
      end

      @(posedge clk);
      #1;
      drive_next();
   endtask

   task automatic do_reset();
      reset = 1'b1; rnd = 0; l2_force = 0; d_reissue = 0; i_reissue = 0;
      d_req_valid = 1'b0; d_req_type = LOAD; d_req_address = '0; d_req_store_word = '0;
      i_req_valid = 1'b0; i_req_address = '0;
      l2_req_fulfilled = 1'b0; l2_req_loaded_word = '0;
      tick();
      tick();
      reset = 1'b0;
      dut_grants.delete();
      dut_i_over_d = 0;
   endtask

   task automatic drain();
      d_reissue = 0; i_reissue = 0; lat = 2;
      for (int k = 0; k < 30; k++) tick();
   endtask

   initial begin
      int   dcnt, icnt, ocnt;
      bit   seen, found;
      logic [1:0] own0, own1;
      logic [AW-1:0] i_addr_seen;
      logic i_type_seen;

      do_reset();
      chk_en = 1;

      // reset state
      tick();
      chk("rst_valid", s_valid, 1'b0);
      chk("rst_owner", s_owner, 2'b00);
      chk("rst_type", s_type, LOAD);
      chk("rst_addr", s_addr, 32'h0);
      chk("rst_store", s_store, 32'h0);
      chk("rst_dful", s_dful, 1'b0);
      chk("rst_iful", s_iful, 1'b0);
      chk("rst_word", s_word, 32'h0);

      // single dcache store
      lat = 3;
      d_req_valid = 1'b1; d_req_type = STORE; d_req_address = 32'h100; d_req_store_word = 32'hDEADBEEF;
      tick();
      chk("t1_arb_cycle_valid", s_valid, 1'b0);
      tick();
      chk("t1_valid", s_valid, 1'b1);
      chk("t1_type", s_type, STORE);
      chk("t1_addr", s_addr, 32'h100);
      chk("t1_data", s_store, 32'hDEADBEEF);
      chk("t1_owner", s_owner, 2'b01);
      dcnt = 0; icnt = 0; seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         tick();
         dcnt += int'(s_dful); icnt += int'(s_iful);
         seen = s_dful;
      end
      chk("t1_fulfilled_seen", seen, 1'b1);
      tick();
      chk("t1_idle_after", s_owner, 2'b00);
      for (int k = 0; k < 4; k++) begin
         dcnt += int'(s_dful); icnt += int'(s_iful);
         tick();
      end
      chk("t1_d_pulses", dcnt, 1);
      chk("t1_i_pulses", icnt, 0);

      // round-robin with both continuously valid
      do_reset();
      lat = 2;
      d_req_valid = 1'b1; d_req_type = LOAD; d_req_address = 32'h300; d_req_store_word = 32'h0; d_reissue = 1;
      i_req_valid = 1'b1; i_req_address = 32'h200; i_reissue = 1;
      tick(); own0 = s_owner;
      tick(); own1 = s_owner;
      seen = 0; i_addr_seen = '0; i_type_seen = 1'bx;
      for (int k = 0; k < 60 && dut_grants.size() < 4; k++) begin
         tick();
         if (s_owner == 2'b10 && !seen) begin
            seen = 1; i_addr_seen = s_addr; i_type_seen = s_type;
         end
      end
      chk("t2_owner_c0", own0, 2'b00);
      chk("t2_owner_c1", own1, 2'b01);
      chk("t2_grant0", gr(0), 1);
      chk("t2_grant1", gr(1), 2);
      chk("t2_grant2", gr(2), 1);
      chk("t2_grant3", gr(3), 2);
      chk("t2_i_seen", seen, 1'b1);
      chk("t2_i_addr", i_addr_seen, 32'h200);
      chk("t2_i_type", i_type_seen, LOAD);
      drain();

      // fixed dcache priority: icache waits until dcache stops re-requesting
      use_fx = 1;
      do_reset();
      lat = 1;
      d_req_valid = 1'b1; d_req_type = LOAD; d_req_address = 32'h340; d_reissue = 1;
      i_req_valid = 1'b1; i_req_address = 32'h280;
      for (int k = 0; k < 40 && dut_grants.size() < 3; k++) tick();
      chk("t3_grant0", gr(0), 1);
      chk("t3_grant1", gr(1), 1);
      chk("t3_grant2", gr(2), 1);
      d_reissue = 0;
      found = 0;
      for (int k = 0; k < 20 && !found; k++) begin
         tick();
         foreach (dut_grants[j]) if (dut_grants[j] == 2) found = 1;
      end
      chk("t3_i_granted", found, 1'b1);
      chk("t3_i_over_valid_d", dut_i_over_d, 0);
      drain();
      use_fx = 0;

      // L2 fulfilled while idle is ignored
      do_reset();
      l2_force = 1; l2_req_fulfilled = 1'b1;
      dcnt = 0; icnt = 0; ocnt = 0;
      for (int k = 0; k < 4; k++) begin
         tick();
         dcnt += int'(s_dful); icnt += int'(s_iful); ocnt += int'(s_owner != 2'b00);
      end
      l2_force = 0;
      chk("t4_d_pulses", dcnt, 0);
      chk("t4_i_pulses", icnt, 0);
      chk("t4_never_granted", ocnt, 0);

      // reset in the middle of an icache grant
      do_reset();
      lat = 50;
      i_req_valid = 1'b1; i_req_address = 32'h240;
      for (int k = 0; k < 5 && s_owner != 2'b10; k++) tick();
      chk("t5_granted_i", s_owner, 2'b10);
      reset = 1'b1;
      d_req_valid = 1'b1; d_req_type = STORE; d_req_address = 32'h380; d_req_store_word = 32'hA5A5;
      tick();
      reset = 1'b0;
      lat = 2;
      tick();
      chk("t5_valid", s_valid, 1'b0);
      chk("t5_owner", s_owner, 2'b00);
      chk("t5_addr", s_addr, 32'h0);
      chk("t5_type", s_type, LOAD);
      chk("t5_iful", s_iful, 1'b0);
      tick();
      chk("t5_tie_to_d", s_owner, 2'b01);
      drain();

      // icache load data returned in the fulfilled cycle
      do_reset();
      lat = 2;
      l2_req_loaded_word = 32'h13579BDF;
      i_req_valid = 1'b1; i_req_address = 32'h2C0;
      seen = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
         tick();
         seen = s_iful;
      end
      chk("t6_iful_seen", seen, 1'b1);
      chk("t6_loaded_word", s_word, 32'h13579BDF);
      drain();

      // randomized traffic, round-robin then fixed priority, with occasional resets
      do_reset();
      rnd = 1;
      for (int k = 0; k < 1500; k++) begin
         reset = ($urandom_range(0, 149) == 0);
         tick();
      end
      reset = 1'b0;
      use_fx = 1;
      do_reset();
      rnd = 1;
      for (int k = 0; k < 1500; k++) begin
         reset = ($urandom_range(0, 149) == 0);
         tick();
      end
      reset = 1'b0;
      rnd = 0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
